// File: rtl/if_trace_buffer.sv
// if_trace_buffer: in-order FIFO of instruction-fetch trace records.
// Converts the IF tracker's level-held ready into a single push per record,
// stores the fetch latency alongside each record, and presents the head
// entry show-ahead over a valid/ready handshake. Records arriving while the
// buffer is full (and nothing pops) are dropped and counted.
module if_trace_buffer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIME_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_data_ready,
  input  logic [ADDR_WIDTH-1:0]      if_addr,
  input  logic [DATA_WIDTH-1:0]      if_instr,
  input  logic [TIME_WIDTH-1:0]      if_time_start,
  input  logic [TIME_WIDTH-1:0]      if_time_end,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic [DATA_WIDTH-1:0]      out_instr,
  output logic [TIME_WIDTH-1:0]      out_time_start,
  output logic [TIME_WIDTH-1:0]      out_time_end,
  output logic [TIME_WIDTH-1:0]      out_latency,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                overflow_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [15:0]      OVF_MAX   = 16'hFFFF;

  // Fetch latency, modulo the timestamp width so counter wrap is harmless.
  function automatic logic [TIME_WIDTH-1:0] calc_latency(
    input logic [TIME_WIDTH-1:0] t_start,
    input logic [TIME_WIDTH-1:0] t_end
  );
    calc_latency = t_end - t_start;
  endfunction

  // Record storage; contents are don't-care after reset.
  logic [ADDR_WIDTH-1:0] addr_mem_r  [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
  logic [TIME_WIDTH-1:0] start_mem_r [DEPTH];
  logic [TIME_WIDTH-1:0] end_mem_r   [DEPTH];
  logic [TIME_WIDTH-1:0] lat_mem_r   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_r;
  logic             empty_r;
  logic             valid_r;
  logic [15:0]      overflow_r;
  logic             ready_prev_r;

  logic             push_s;
  logic             pop_s;
  logic             wr_en_s;
  logic             drop_s;
  logic [CNT_W-1:0] count_next_s;

  // Decode push/pop/drop for this cycle and the resulting occupancy.
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    wr_en_s      = 1'b0;
    drop_s       = 1'b0;
    count_next_s = count_r;
    push_s = if_data_ready & ~ready_prev_r;
    pop_s  = valid_r & out_ready;
    if (flush) begin
      wr_en_s      = 1'b0;
      drop_s       = 1'b0;
      count_next_s = '0;
    end else begin
      // A pop in the same cycle frees a slot, so a full buffer still accepts.
      wr_en_s = push_s & (~full_r | pop_s);
      drop_s  = push_s & full_r & ~pop_s;
      case ({wr_en_s, pop_s})
        2'b10:   count_next_s = count_r + CNT_ONE;
        2'b01:   count_next_s = count_r - CNT_ONE;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Edge-detect history; resets high so a record held across reset is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_prev_r <= 1'b1;
    end else begin
      ready_prev_r <= if_data_ready;
    end
  end

  // Pointers, occupancy and derived status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      valid_r  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_DEPTH);
      empty_r <= (count_next_s == '0);
      valid_r <= (count_next_s != '0);
    end
  end

  // Saturating count of records lost to overflow; flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 16'h0000;
    end else if (drop_s && (overflow_r != OVF_MAX)) begin
      overflow_r <= overflow_r + 16'h0001;
    end
  end

  // Write the captured record and its latency at the tail slot.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      addr_mem_r[wr_ptr_r]  <= if_addr;
      instr_mem_r[wr_ptr_r] <= if_instr;
      start_mem_r[wr_ptr_r] <= if_time_start;
      end_mem_r[wr_ptr_r]   <= if_time_end;
      lat_mem_r[wr_ptr_r]   <= calc_latency(if_time_start, if_time_end);
    end
  end

  // Show-ahead head record, forced to zero while the buffer is empty.
  always_comb begin
    out_addr       = '0;
    out_instr      = '0;
    out_time_start = '0;
    out_time_end   = '0;
    out_latency    = '0;
    if (empty_r) begin
      out_addr       = '0;
      out_instr      = '0;
      out_time_start = '0;
      out_time_end   = '0;
      out_latency    = '0;
    end else begin
      out_addr       = addr_mem_r[rd_ptr_r];
      out_instr      = instr_mem_r[rd_ptr_r];
      out_time_start = start_mem_r[rd_ptr_r];
      out_time_end   = end_mem_r[rd_ptr_r];
      out_latency    = lat_mem_r[rd_ptr_r];
    end
  end

  assign out_valid      = valid_r;
  assign count          = count_r;
  assign full           = full_r;
  assign empty          = empty_r;
  assign overflow_count = overflow_r;

endmodule

// File: tb/tb_if_trace_buffer.sv
// Directed self-checking bench for if_trace_buffer (DEPTH = 8).
module tb_if_trace_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_data_ready;
  logic [31:0] if_addr;
  logic [31:0] if_instr;
  logic [31:0] if_time_start;
  logic [31:0] if_time_end;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_instr;
  logic [31:0] out_time_start;
  logic [31:0] out_time_end;
  logic [31:0] out_latency;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] overflow_count;

  int err_cnt;
  int chk_cnt;

  if_trace_buffer #(
    .DEPTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIME_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_data_ready(if_data_ready), .if_addr(if_addr), .if_instr(if_instr),
    .if_time_start(if_time_start), .if_time_end(if_time_end),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr),
    .out_time_start(out_time_start), .out_time_end(out_time_end),
    .out_latency(out_latency), .count(count), .full(full), .empty(empty),
    .overflow_count(overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs and checks happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] ins,
                         input logic [31:0] ts, input logic [31:0] te);
    if_addr       = a;
    if_instr      = ins;
    if_time_start = ts;
    if_time_end   = te;
    if_data_ready = 1'b1;
  endtask

  // One full record: rising edge, then one idle cycle.
  task automatic push_rec(input logic [31:0] a, input logic [31:0] ts, input logic [31:0] te);
    present(a, 32'h0000_0013, ts, te);
    step();
    if_data_ready = 1'b0;
    step();
  endtask

  initial begin
    err_cnt       = 0;
    chk_cnt       = 0;
    rst           = 1'b0;
    flush         = 1'b0;
    out_ready     = 1'b0;
    if_data_ready = 1'b1;
    if_addr       = 32'h0000_0000;
    if_instr      = 32'h0000_0000;
    if_time_start = 32'h0000_0000;
    if_time_end   = 32'h0000_0000;
    step();
    step();
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_ovf", 64'(overflow_count), 64'd0);
    check_eq("rst_addr", 64'(out_addr), 64'd0);
    check_eq("rst_lat", 64'(out_latency), 64'd0);

    // Release reset with the level already high: nothing is captured.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_eq("held_count", 64'(count), 64'd0);
    check_eq("held_empty", 64'(empty), 64'd1);
    if_data_ready = 1'b0;
    step();

    // Single record, level held long.
    present(32'h0000_0100, 32'h0000_0013, 32'd10, 32'd14);
    step();
    check_eq("r1_valid", 64'(out_valid), 64'd1);
    check_eq("r1_lat", 64'(out_latency), 64'd4);
    check_eq("r1_count", 64'(count), 64'd1);
    check_eq("r1_addr", 64'(out_addr), 64'h100);
    check_eq("r1_instr", 64'(out_instr), 64'h13);
    check_eq("r1_tend", 64'(out_time_end), 64'd14);
    for (int i = 0; i < 10; i++) step();
    check_eq("r1_hold_count", 64'(count), 64'd1);
    if_data_ready = 1'b0;
    out_ready     = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("r1_pop_empty", 64'(empty), 64'd1);
    check_eq("r1_pop_addr", 64'(out_addr), 64'd0);

    // Latency across timestamp wrap.
    present(32'h0000_0180, 32'h0000_0013, 32'hFFFF_FFFE, 32'h0000_0003);
    step();
    check_eq("wrap_lat", 64'(out_latency), 64'd5);
    if_data_ready = 1'b0;
    out_ready     = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("wrap_pop_count", 64'(count), 64'd0);

    // Ten records into an eight-deep buffer.
    for (int i = 0; i < 10; i++) begin
      push_rec(32'h0000_0200 + 32'(4 * i), 32'(i), 32'(i + 3));
    end
    check_eq("burst_full", 64'(full), 64'd1);
    check_eq("burst_count", 64'(count), 64'd8);
    check_eq("burst_ovf", 64'(overflow_count), 64'd2);
    check_eq("burst_head", 64'(out_addr), 64'h200);
    check_eq("burst_lat", 64'(out_latency), 64'd3);

    // Full buffer: push coincides with pop, record accepted as tail.
    out_ready = 1'b1;
    present(32'h0000_0300, 32'h0000_0013, 32'd100, 32'd107);
    step();
    out_ready     = 1'b0;
    if_data_ready = 1'b0;
    check_eq("pp_count", 64'(count), 64'd8);
    check_eq("pp_ovf", 64'(overflow_count), 64'd2);
    check_eq("pp_head", 64'(out_addr), 64'h204);
    step();

    // Drain: remaining burst records in order, then the new tail.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_a;
      exp_a = (i < 7) ? 32'h0000_0204 + 32'(4 * i) : 32'h0000_0300;
      check_eq($sformatf("drain_addr%0d", i), 64'(out_addr), 64'(exp_a));
      step();
    end
    out_ready = 1'b0;
    check_eq("drain_empty", 64'(empty), 64'd1);
    check_eq("drain_valid", 64'(out_valid), 64'd0);

    // Flush coinciding with a push while three entries are held.
    push_rec(32'h0000_0500, 32'd1, 32'd2);
    push_rec(32'h0000_0504, 32'd1, 32'd2);
    push_rec(32'h0000_0508, 32'd1, 32'd2);
    check_eq("pre_flush_count", 64'(count), 64'd3);
    present(32'h0000_050C, 32'h0000_0013, 32'd1, 32'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_ovf", 64'(overflow_count), 64'd2);
    check_eq("flush_empty", 64'(empty), 64'd1);
    check_eq("flush_addr", 64'(out_addr), 64'd0);
    // Level still held after flush: no new capture.
    step();
    check_eq("flush_hold_count", 64'(count), 64'd0);
    if_data_ready = 1'b0;
    step();
    push_rec(32'h0000_0400, 32'd20, 32'd29);
    check_eq("post_flush_count", 64'(count), 64'd1);
    check_eq("post_flush_addr", 64'(out_addr), 64'h400);
    check_eq("post_flush_lat", 64'(out_latency), 64'd9);

    // Reset mid-occupancy clears state.
    push_rec(32'h0000_0404, 32'd0, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("midrst_count", 64'(count), 64'd0);
    check_eq("midrst_ovf", 64'(overflow_count), 64'd0);
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
